fetch_unit: RTL

//  Instruction fetch stage of the TinyRisc-V core. Owns the architectural PC and

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: control/datapath inputs, imem req/ack channel,
// and the instruction presented to decode. master = fetch_unit side.
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif
`ifndef SEL_PC_NONE
`define SEL_PC_NONE 2'b00
`endif

interface fetch_if;
  logic [`SEL_PC_WIDTH-1:0] pc_sel_i;
  logic                     br_taken_i;
  logic [31:0]              next_pc_i;
  logic                     fetch_stall_i;
  logic                     imem_req_o;
  logic [31:0]              imem_addr_o;
  logic                     imem_ack_i;
  logic [31:0]              imem_rdata_i;
  logic [31:0]              ir_o;
  logic [31:0]              pc_o;
  logic                     ir_valid_o;
  logic                     fetch_err_o;

  modport master (
    input  pc_sel_i, br_taken_i, next_pc_i, fetch_stall_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o, fetch_err_o
  );

  modport slave (
    output pc_sel_i, br_taken_i, next_pc_i, fetch_stall_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o, fetch_err_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over
// req/ack, holds the fetched instruction until control advances it.
// A redirect during an outstanding fetch cannot cancel the request, so the
// in-flight response is marked killed and dropped, then the new PC is fetched.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  localparam int          TW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   req_addr_q;
  logic          kill_q;
  logic [TW-1:0] tmo_q;

  logic          advance;
  logic          redirect;
  logic          redir_bad;
  logic [31:0]   target;

  // Decode control request: advance needs a PC select and no datapath stall.
  always_comb begin
    advance   = (bus.pc_sel_i != `SEL_PC_NONE) && !bus.fetch_stall_i;
    redirect  = advance && bus.br_taken_i;
    redir_bad = redirect && (bus.next_pc_i[1:0] != 2'b00);
    target    = bus.br_taken_i ? bus.next_pc_i : bus.pc_o + 32'd4;
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc_q            <= RESET_PC;
      req_addr_q      <= RESET_PC;
      kill_q          <= 1'b0;
      tmo_q           <= '0;
      bus.imem_req_o  <= 1'b0;
      bus.imem_addr_o <= RESET_PC;
      bus.ir_o        <= NOP;
      bus.pc_o        <= RESET_PC;
      bus.ir_valid_o  <= 1'b0;
      bus.fetch_err_o <= 1'b0;
    end else begin
      case (state)
        // One dead cycle (after reset or after a dropped response), then fetch pc_q.
        IDLE: begin
          state           <= FETCH;
          req_addr_q      <= pc_q;
          bus.imem_addr_o <= pc_q;
          bus.imem_req_o  <= 1'b1;
          tmo_q           <= '0;
        end

        FETCH: begin
          if (redir_bad) begin
            state           <= ERR;
            bus.imem_req_o  <= 1'b0;
            bus.ir_valid_o  <= 1'b0;
            bus.fetch_err_o <= 1'b1;
          end else if (bus.imem_ack_i) begin
            tmo_q          <= '0;
            bus.imem_req_o <= 1'b0;
            if (kill_q || redirect) begin
              // Stale response: discard and refetch from the redirected PC.
              if (redirect) pc_q <= bus.next_pc_i;
              kill_q <= 1'b0;
              state  <= IDLE;
            end else begin
              bus.ir_o       <= bus.imem_rdata_i;
              bus.pc_o       <= req_addr_q;
              bus.ir_valid_o <= 1'b1;
              state          <= HOLD;
            end
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            state           <= ERR;
            bus.imem_req_o  <= 1'b0;
            bus.ir_valid_o  <= 1'b0;
            bus.fetch_err_o <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            // Request address stays put until ack; remember the new PC instead.
            if (redirect) begin
              pc_q   <= bus.next_pc_i;
              kill_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (advance) begin
            if (target[1:0] != 2'b00) begin
              state           <= ERR;
              bus.ir_valid_o  <= 1'b0;
              bus.fetch_err_o <= 1'b1;
            end else begin
              pc_q            <= target;
              req_addr_q      <= target;
              bus.imem_addr_o <= target;
              bus.imem_req_o  <= 1'b1;
              bus.ir_valid_o  <= 1'b0;
              tmo_q           <= '0;
              state           <= FETCH;
            end
          end
        end

        // Sticky until reset.
        default: begin
          bus.imem_req_o  <= 1'b0;
          bus.ir_valid_o  <= 1'b0;
          bus.fetch_err_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
